// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - pipeline stall/flush/bubble controller with memory-wait watchdog (optional HAZARD_PERF_EN counters)
module hazard_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  reg_src1_id,
    input  logic [4:0]  reg_src2_id,
    input  logic [4:0]  reg_dest_exe,
    input  logic        reg_w_en_exe,
    input  logic        mem_read_exe,
    input  logic        branch_taken_exe,
    input  logic        dmem_req_mem,
    input  logic        dmem_ready,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_stall,
    output logic        ex_mem_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_bubble,
    output logic        mem_timeout,
`ifdef HAZARD_PERF_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events,
`endif
    output logic [1:0]  hazard_cause
);

    typedef enum logic {
        RUN       = 1'b0,
        DMEM_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             freeze;
    logic             timeout_hit;
    logic             load_use;
    logic [1:0]       cause_nxt;

    // Memory-wait sequencing: decides freeze, watchdog expiry and next state/counter
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        freeze       = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            RUN: begin
                if (dmem_req_mem && !dmem_ready) begin
                    freeze       = 1'b1;
                    state_nxt    = DMEM_WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            DMEM_WAIT: begin
                // A dropped request here is a protocol error; keep waiting regardless
                wait_cnt_nxt = wait_cnt + CNT_W'(1);
                if (dmem_ready) begin
                    state_nxt = RUN;
                end else if (wait_cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = RUN;
                end else begin
                    freeze = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Load-use detection against the load currently in EX ($0 never hazards)
    always_comb begin
        load_use = mem_read_exe && reg_w_en_exe && (reg_dest_exe != 5'd0) &&
                   ((reg_src1_id == reg_dest_exe) || (reg_src2_id == reg_dest_exe));
    end

    // Per-stage controls: freeze dominates, then branch, then load-use; all quiet in reset
    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_stall   = 1'b0;
        ex_mem_stall  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        cause_nxt     = 2'd0;
        if (rst_n) begin
            if (freeze) begin
                pc_stall      = 1'b1;
                if_id_stall   = 1'b1;
                id_ex_stall   = 1'b1;
                ex_mem_stall  = 1'b1;
                mem_wb_bubble = 1'b1;
                cause_nxt     = 2'd3;
            end else if (branch_taken_exe) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                cause_nxt   = 2'd2;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
                cause_nxt   = 2'd1;
            end
        end
    end

    // State, wait counter, sticky watchdog flag and last-cycle cause
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            hazard_cause <= 2'd0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_cnt_nxt;
            hazard_cause <= cause_nxt;
            if (timeout_hit) begin
                mem_timeout <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    // Free-running event counters, wrapping at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (pc_stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (if_id_flush) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - directed self-checking bench for hazard_sequencer
module tb_hazard_sequencer;

    localparam logic [6:0] C_NONE   = 7'b0000000;
    localparam logic [6:0] C_FREEZE = 7'b1111001;
    localparam logic [6:0] C_BRANCH = 7'b0000110;
    localparam logic [6:0] C_LDUSE  = 7'b1100010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] reg_src1_id, reg_src2_id, reg_dest_exe;
    logic       reg_w_en_exe, mem_read_exe, branch_taken_exe;
    logic       dmem_req_mem, dmem_ready;
    logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic       if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout;
    logic [1:0] hazard_cause;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_events;
`endif
    logic [6:0] ctl;

    int n_cmp = 0;
    int n_err = 0;

    assign ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                  if_id_flush, id_ex_flush, mem_wb_bubble};

    always #5 clk = ~clk;

    hazard_sequencer #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .reg_src1_id(reg_src1_id), .reg_src2_id(reg_src2_id),
        .reg_dest_exe(reg_dest_exe), .reg_w_en_exe(reg_w_en_exe),
        .mem_read_exe(mem_read_exe), .branch_taken_exe(branch_taken_exe),
        .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_bubble(mem_wb_bubble), .mem_timeout(mem_timeout),
`ifdef HAZARD_PERF_EN
        .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
        .hazard_cause(hazard_cause)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        reg_src1_id = 5'd0; reg_src2_id = 5'd0; reg_dest_exe = 5'd0;
        reg_w_en_exe = 1'b0; mem_read_exe = 1'b0; branch_taken_exe = 1'b0;
        dmem_req_mem = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        branch_taken_exe = 1'b1; dmem_req_mem = 1'b1; dmem_ready = 1'b0;
        mem_read_exe = 1'b1; reg_w_en_exe = 1'b1; reg_dest_exe = 5'd3; reg_src1_id = 5'd3;
        step();
        #1;
        n_cmp++;
        if (ctl !== C_NONE) begin n_err++; $display("FAIL reset_ctl got %b want %b", ctl, C_NONE); end
        n_cmp++;
        if (mem_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %b want 0", mem_timeout); end
        n_cmp++;
        if (hazard_cause !== 2'd0) begin n_err++; $display("FAIL reset_cause got %0d want 0", hazard_cause); end
        clear_inputs();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_load_use();
        mem_read_exe = 1'b1; reg_w_en_exe = 1'b1; reg_dest_exe = 5'd5; reg_src2_id = 5'd5; reg_src1_id = 5'd7;
        #1;
        n_cmp++;
        if (ctl !== C_LDUSE) begin n_err++; $display("FAIL load_use_ctl got %b want %b", ctl, C_LDUSE); end
        step();
        clear_inputs();
        #1;
        n_cmp++;
        if (hazard_cause !== 2'd1) begin n_err++; $display("FAIL load_use_cause got %0d want 1", hazard_cause); end
        n_cmp++;
        if (ctl !== C_NONE) begin n_err++; $display("FAIL load_use_clear got %b want %b", ctl, C_NONE); end
        step();
        n_cmp++;
        if (hazard_cause !== 2'd0) begin n_err++; $display("FAIL load_use_cause_clr got %0d want 0", hazard_cause); end
    endtask

    task automatic test_load_zero();
        mem_read_exe = 1'b1; reg_w_en_exe = 1'b1; reg_dest_exe = 5'd0; reg_src1_id = 5'd0;
        #1;
        n_cmp++;
        if (ctl !== C_NONE) begin n_err++; $display("FAIL load_zero_ctl got %b want %b", ctl, C_NONE); end
        step();
        clear_inputs();
        n_cmp++;
        if (hazard_cause !== 2'd0) begin n_err++; $display("FAIL load_zero_cause got %0d want 0", hazard_cause); end
    endtask

    task automatic test_mem_wait(input logic br);
        logic [6:0] rel_ctl;
        logic [1:0] rel_cause;
        rel_ctl   = br ? C_BRANCH : C_NONE;
        rel_cause = br ? 2'd2 : 2'd0;
        dmem_req_mem = 1'b1; dmem_ready = 1'b0; branch_taken_exe = br;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (ctl !== C_FREEZE) begin n_err++; $display("FAIL wait_frozen[%0d] br=%b got %b want %b", i, br, ctl, C_FREEZE); end
            step();
            n_cmp++;
            if (hazard_cause !== 2'd3) begin n_err++; $display("FAIL wait_cause[%0d] br=%b got %0d want 3", i, br, hazard_cause); end
        end
        dmem_ready = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== rel_ctl) begin n_err++; $display("FAIL wait_release br=%b got %b want %b", br, ctl, rel_ctl); end
        step();
        n_cmp++;
        if (hazard_cause !== rel_cause) begin n_err++; $display("FAIL wait_rel_cause br=%b got %0d want %0d", br, hazard_cause, rel_cause); end
        // Back in RUN: a request that is ready immediately must not stall
        branch_taken_exe = 1'b0; dmem_req_mem = 1'b1; dmem_ready = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== C_NONE) begin n_err++; $display("FAIL wait_run_ready br=%b got %b want %b", br, ctl, C_NONE); end
        step();
        clear_inputs();
    endtask

    task automatic test_timeout();
        // Reset mid-wait must leave RUN with a cleared counter
        dmem_req_mem = 1'b1; dmem_ready = 1'b0;
        step(); step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== C_NONE) begin n_err++; $display("FAIL midwait_reset_ctl got %b want %b", ctl, C_NONE); end
        step();
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ctl !== C_FREEZE) begin n_err++; $display("FAIL timeout_frozen[%0d] got %b want %b", i, ctl, C_FREEZE); end
            n_cmp++;
            if (mem_timeout !== 1'b0) begin n_err++; $display("FAIL timeout_early[%0d] got %b want 0", i, mem_timeout); end
            step();
        end
        dmem_req_mem = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== C_NONE) begin n_err++; $display("FAIL timeout_release got %b want %b", ctl, C_NONE); end
        step();
        n_cmp++;
        if (mem_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_flag got %b want 1", mem_timeout); end
        n_cmp++;
        if (ctl !== C_NONE) begin n_err++; $display("FAIL timeout_run got %b want %b", ctl, C_NONE); end
        step();
        n_cmp++;
        if (mem_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_sticky got %b want 1", mem_timeout); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mem_timeout !== 1'b0) begin n_err++; $display("FAIL timeout_reset got %b want 0", mem_timeout); end
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_branch_load_use();
        pulse_reset();
`ifdef HAZARD_PERF_EN
        n_cmp++;
        if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
            n_err++; $display("FAIL perf_reset got stall=%0d flush=%0d want 0/0", stall_cycles, flush_events);
        end
`endif
        branch_taken_exe = 1'b1;
        mem_read_exe = 1'b1; reg_w_en_exe = 1'b1; reg_dest_exe = 5'd9; reg_src1_id = 5'd9;
        #1;
        n_cmp++;
        if (ctl !== C_BRANCH) begin n_err++; $display("FAIL br_lu_ctl got %b want %b", ctl, C_BRANCH); end
        step();
        clear_inputs();
        n_cmp++;
        if (hazard_cause !== 2'd2) begin n_err++; $display("FAIL br_lu_cause got %0d want 2", hazard_cause); end
`ifdef HAZARD_PERF_EN
        n_cmp++;
        if (flush_events !== 32'd1) begin n_err++; $display("FAIL perf_flush got %0d want 1", flush_events); end
        n_cmp++;
        if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL perf_stall got %0d want 0", stall_cycles); end
`endif
        step();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #2;
        test_reset();
        test_load_use();
        test_load_zero();
        test_mem_wait(1'b0);
        test_mem_wait(1'b1);
        test_timeout();
        test_branch_load_use();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
